gci_extio_responder: RTL

//  GCI-side endpoint of the EXTIO link: accepts single-beat read/write requests from the

---
 rtl/gci_extio_pkg.sv | 19 +
 rtl/gci_irq_priority_encoder.sv | 21 ++
 rtl/gci_extio_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/gci_extio_pkg.sv
// GCI EXTIO responder shared types and constants.
// FSM encodings and bus-level constants used across the slice.
package gci_extio_pkg;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_DEV,
      BUS_RET
   } bus_st_e;

   typedef enum logic {
      IRQ_IDLE,
      IRQ_PRESENT
   } irq_st_e;

   localparam logic [31:0] GCI_EXTIO_ERR_DATA = 32'hFFFF_FFFF;
   localparam logic        EXTIO_RW_WRITE     = 1'b1;

endpackage

// File: rtl/gci_irq_priority_encoder.sv
// Lowest-index-first priority encoder for pending IRQ lines.
// Purely combinational; idx_o is don't-care when valid_o is low.
module gci_irq_priority_encoder #(
   parameter int P_IRQ_N = 8,
   parameter int P_IW    = (P_IRQ_N > 1) ? $clog2(P_IRQ_N) : 1
) (
   input  logic [P_IRQ_N-1:0] pend_i,
   output logic               valid_o,
   output logic [P_IW-1:0]    idx_o
);

   // Scan high to low so the lowest set index is the final winner.
   always_comb begin
      valid_o = |pend_i;
      idx_o   = '0;
      for (int i = P_IRQ_N - 1; i >= 0; i--) begin
         if (pend_i[i]) idx_o = P_IW'(i);
      end
   end

endmodule

// File: rtl/gci_extio_responder.sv
// GCI-side EXTIO endpoint: single-beat device bus access
// with read return, plus edge-collected IRQ presentation.
module gci_extio_responder
   import gci_extio_pkg::*;
#(
   parameter logic [31:0] P_BASE     = 32'h0000_0000,
   parameter logic [31:0] P_MASK     = 32'hFFFF_F000,
   parameter int          P_OFS_W    = 10,
   parameter int          P_TIMEOUT  = 256,
   parameter int          P_IRQ_N    = 8,
   parameter logic [5:0]  P_IRQ_BASE = 6'd0
) (
   input  logic               iCLOCK,
   input  logic               inRESET,
   input  logic               iRESET_SYNC,
   input  logic               iEXTIO_REQ,
   output logic               oEXTIO_BUSY,
   input  logic               iEXTIO_RW,
   input  logic [31:0]        iEXTIO_ADDR,
   input  logic [31:0]        iEXTIO_DATA,
   output logic               oEXTIO_REQ,
   input  logic               iEXTIO_BUSY,
   output logic [31:0]        oEXTIO_DATA,
   output logic               oEXTIO_IRQ_REQ,
   output logic [5:0]         oEXTIO_IRQ_NUM,
   input  logic               iEXTIO_IRQ_ACK,
   output logic               oDEV_REQ,
   output logic               oDEV_RW,
   output logic [P_OFS_W-1:0] oDEV_ADDR,
   output logic [31:0]        oDEV_DATA,
   input  logic               iDEV_ACK,
   input  logic [31:0]        iDEV_DATA,
   input  logic [P_IRQ_N-1:0] iDEV_IRQ
);

   localparam int TW = ($clog2(P_TIMEOUT) < 8) ? 8 : $clog2(P_TIMEOUT);
   localparam int IW = (P_IRQ_N > 1) ? $clog2(P_IRQ_N) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(P_TIMEOUT - 1);

   bus_st_e              bus_q;
   logic                 busy_q;
   logic                 dreq_q;
   logic                 drw_q;
   logic [P_OFS_W-1:0]   dadr_q;
   logic [31:0]          ddat_q;
   logic [TW-1:0]        tmr_q;
   logic [31:0]          rdat_q;
   logic                 xreq_q;
   logic [31:0]          xdat_q;

   irq_st_e              irq_q;
   logic [P_IRQ_N-1:0]   hist_q;
   logic                 arm_q;
   logic [P_IRQ_N-1:0]   pend_q;
   logic [P_IRQ_N-1:0]   pend_d;
   logic [IW-1:0]        kidx_q;
   logic                 ireq_q;
   logic [5:0]           inum_q;

   logic                 hit;
   logic                 ret_go;
   logic [31:0]          ret_val;
   logic [P_IRQ_N-1:0]   irq_edge;
   logic [P_IRQ_N-1:0]   clr_mask;
   logic                 enc_valid;
   logic [IW-1:0]        enc_idx;

   assign hit = (iEXTIO_ADDR & P_MASK) == P_BASE;

   // Decide whether this edge enters RET, and with which data.
   always_comb begin
      ret_go  = 1'b0;
      ret_val = GCI_EXTIO_ERR_DATA;
      unique case (bus_q)
         BUS_IDLE: begin
            ret_go = iEXTIO_REQ && !hit && (iEXTIO_RW != EXTIO_RW_WRITE);
         end
         BUS_DEV: begin
            if (drw_q != EXTIO_RW_WRITE) begin
               if (iDEV_ACK) begin
                  ret_go  = 1'b1;
                  ret_val = iDEV_DATA;
               end else if (tmr_q == '0) begin
                  ret_go = 1'b1;
               end
            end
         end
         default: ret_go = 1'b0;
      endcase
   end

   // Bus FSM: accept, run device access with timeout, return read data.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         bus_q  <= BUS_IDLE;
         busy_q <= 1'b0;
         dreq_q <= 1'b0;
         drw_q  <= 1'b0;
         dadr_q <= '0;
         ddat_q <= '0;
         tmr_q  <= '0;
         rdat_q <= '0;
         xreq_q <= 1'b0;
         xdat_q <= '0;
      end else if (iRESET_SYNC) begin
         bus_q  <= BUS_IDLE;
         busy_q <= 1'b0;
         dreq_q <= 1'b0;
         drw_q  <= 1'b0;
         dadr_q <= '0;
         ddat_q <= '0;
         tmr_q  <= '0;
         rdat_q <= '0;
         xreq_q <= 1'b0;
         xdat_q <= '0;
      end else begin
         dreq_q <= 1'b0;
         xreq_q <= 1'b0;
         if (ret_go) begin
            bus_q  <= BUS_RET;
            busy_q <= 1'b1;
            rdat_q <= ret_val;
            if (!iEXTIO_BUSY) begin
               xreq_q <= 1'b1;
               xdat_q <= ret_val;
            end
         end else begin
            unique case (bus_q)
               BUS_IDLE: begin
                  if (iEXTIO_REQ && hit) begin
                     drw_q  <= iEXTIO_RW;
                     dadr_q <= iEXTIO_ADDR[P_OFS_W+1:2];
                     ddat_q <= iEXTIO_DATA;
                     dreq_q <= 1'b1;
                     tmr_q  <= TMR_LOAD;
                     bus_q  <= BUS_DEV;
                     busy_q <= 1'b1;
                  end
               end
               BUS_DEV: begin
                  // Only writes reach here on ACK or expiry.
                  if (iDEV_ACK || tmr_q == '0) begin
                     bus_q  <= BUS_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     tmr_q <= tmr_q - TW'(1);
                  end
               end
               BUS_RET: begin
                  if (xreq_q) begin
                     bus_q  <= BUS_IDLE;
                     busy_q <= 1'b0;
                  end else if (!iEXTIO_BUSY) begin
                     xreq_q <= 1'b1;
                     xdat_q <= rdat_q;
                  end
               end
               default: begin
                  bus_q  <= BUS_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Edges are masked for one cycle after async reset so the
   // history can load the live line levels first.
   assign irq_edge = iDEV_IRQ & ~hist_q & {P_IRQ_N{arm_q}};

   // Clear the presented line on ACK; a same-cycle edge re-sets it.
   always_comb begin
      clr_mask = '0;
      if (irq_q == IRQ_PRESENT && iEXTIO_IRQ_ACK) clr_mask[kidx_q] = 1'b1;
      pend_d = (pend_q & ~clr_mask) | irq_edge;
   end

   gci_irq_priority_encoder #(
      .P_IRQ_N (P_IRQ_N),
      .P_IW    (IW)
   ) u_enc (
      .pend_i  (pend_q),
      .valid_o (enc_valid),
      .idx_o   (enc_idx)
   );

   // IRQ FSM: pick lowest pending line, hold it until acknowledged.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         irq_q  <= IRQ_IDLE;
         hist_q <= '0;
         arm_q  <= 1'b0;
         pend_q <= '0;
         kidx_q <= '0;
         ireq_q <= 1'b0;
         inum_q <= '0;
      end else if (iRESET_SYNC) begin
         irq_q  <= IRQ_IDLE;
         hist_q <= iDEV_IRQ;
         arm_q  <= 1'b1;
         pend_q <= '0;
         kidx_q <= '0;
         ireq_q <= 1'b0;
         inum_q <= '0;
      end else begin
         hist_q <= iDEV_IRQ;
         arm_q  <= 1'b1;
         pend_q <= pend_d;
         unique case (irq_q)
            IRQ_IDLE: begin
               if (enc_valid) begin
                  kidx_q <= enc_idx;
                  ireq_q <= 1'b1;
                  inum_q <= P_IRQ_BASE + 6'(enc_idx);
                  irq_q  <= IRQ_PRESENT;
               end
            end
            IRQ_PRESENT: begin
               if (iEXTIO_IRQ_ACK) begin
                  ireq_q <= 1'b0;
                  irq_q  <= IRQ_IDLE;
               end
            end
            default: irq_q <= IRQ_IDLE;
         endcase
      end
   end

   assign oEXTIO_BUSY    = busy_q;
   assign oEXTIO_REQ     = xreq_q;
   assign oEXTIO_DATA    = xdat_q;
   assign oEXTIO_IRQ_REQ = ireq_q;
   assign oEXTIO_IRQ_NUM = inum_q;
   assign oDEV_REQ       = dreq_q;
   assign oDEV_RW        = drw_q;
   assign oDEV_ADDR      = dadr_q;
   assign oDEV_DATA      = ddat_q;

endmodule
